// File: rtl/alu_pipe_param_if.sv
// Request/result bundle for alu_pipe_param: operands and opcode in, registered result and flags out.
interface alu_pipe_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             DinL;
    logic             DinR;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             Cout;
    logic             Z;
    logic             N;
    logic             V;

    modport master (
        output in_valid, A, B, Cin, DinL, DinR, sel, out_ready,
        input  in_ready, out_valid, F, Cout, Z, N, V
    );

    modport slave (
        input  in_valid, A, B, Cin, DinL, DinR, sel, out_ready,
        output in_ready, out_valid, F, Cout, Z, N, V
    );
endinterface

// File: rtl/alu_pipe_param.sv
// Pipelined ALU: single-cycle arithmetic/logic/1-bit shifts, multi-cycle N-bit shifts.
// Define ALU_PIPE_FLAGS_EN to build the Z/N/V flag logic; otherwise those outputs are tied low.
module alu_pipe_param #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    alu_pipe_param_if.slave   bus
);
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SHL1 = 4'b1000;
    localparam logic [3:0] OP_SHR1 = 4'b1001;
    localparam logic [3:0] OP_ROL1 = 4'b1010;
    localparam logic [3:0] OP_ROR1 = 4'b1011;
    localparam logic [3:0] OP_SHLN = 4'b1100;
    localparam logic [3:0] OP_SHRN = 4'b1101;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shift_amt;
    logic             shift_right;
    logic             accept;
    logic             is_multi;
    logic             load_single;
    logic             start_shift;
    logic             finish_shift;

    logic [WIDTH-1:0] f_q;
    logic             cout_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic [WIDTH-1:0] alu_f;
    logic             alu_cout;

    assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.F         = f_q;
    assign bus.Cout      = cout_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign shift_amt = bus.B[SHW-1:0];
    assign is_multi  = ((bus.sel == OP_SHLN) || (bus.sel == OP_SHRN)) && (shift_amt != '0);
    assign work_step = shift_right ? (work >> 1) : (work << 1);

    // SUB, INC and DEC all reuse the one adder by choosing its second operand and carry-in.
    always_comb begin
        add_b   = bus.B;
        add_cin = bus.Cin;
        case (bus.sel[1:0])
            2'b01:   begin add_b = ~bus.B;          add_cin = 1'b1; end
            2'b10:   begin add_b = '0;              add_cin = 1'b1; end
            2'b11:   begin add_b = {WIDTH{1'b1}};   add_cin = 1'b0; end
            default: begin add_b = bus.B;           add_cin = bus.Cin; end
        endcase
    end

    assign {add_c, add_s} = {1'b0, bus.A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    // A zero-amount N-bit shift completes in one cycle and simply passes A through.
    always_comb begin
        alu_f    = '0;
        alu_cout = 1'b0;
        if (bus.sel[3:2] == 2'b00) begin
            alu_f    = add_s;
            alu_cout = add_c;
        end else begin
            case (bus.sel)
                OP_AND:  alu_f = bus.A & bus.B;
                OP_OR:   alu_f = bus.A | bus.B;
                OP_XOR:  alu_f = bus.A ^ bus.B;
                OP_NOT:  alu_f = ~bus.A;
                OP_SHL1: alu_f = {bus.A[WIDTH-2:0], bus.DinL};
                OP_SHR1: alu_f = {bus.DinR, bus.A[WIDTH-1:1]};
                OP_ROL1: alu_f = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
                OP_ROR1: alu_f = {bus.A[0], bus.A[WIDTH-1:1]};
                OP_SHLN: alu_f = bus.A;
                OP_SHRN: alu_f = bus.A;
                default: alu_f = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_single  = 1'b0;
        start_shift  = 1'b0;
        finish_shift = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_multi) begin
                        start_shift = 1'b1;
                        state_next  = SHIFT;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt == SHW'(1)) begin
                    finish_shift = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Amounts >= WIDTH (non power-of-two widths) shift everything out and naturally yield zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            work        <= '0;
            cnt         <= '0;
            shift_right <= 1'b0;
        end else begin
            if (load_single) begin
                f_q         <= alu_f;
                cout_q      <= alu_cout;
                out_valid_q <= 1'b1;
            end else if (finish_shift) begin
                f_q         <= work_step;
                cout_q      <= 1'b0;
                out_valid_q <= 1'b1;
            end else if (start_shift || bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (start_shift) begin
                work        <= bus.A;
                cnt         <= shift_amt;
                shift_right <= bus.sel[0];
            end else if (state == SHIFT) begin
                work <= work_step;
                cnt  <= cnt - SHW'(1);
            end
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic alu_v;
    logic z_q, n_q, v_q;

    // Signed overflow: both adder operands share a sign that the sum does not.
    assign alu_v = (bus.sel[3:2] == 2'b00)
                   && (bus.A[WIDTH-1] == add_b[WIDTH-1])
                   && (add_s[WIDTH-1] != bus.A[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (load_single) begin
            z_q <= (alu_f == '0);
            n_q <= alu_f[WIDTH-1];
            v_q <= alu_v;
        end else if (finish_shift) begin
            z_q <= (work_step == '0);
            n_q <= work_step[WIDTH-1];
            v_q <= 1'b0;
        end
    end

    assign bus.Z = z_q;
    assign bus.N = n_q;
    assign bus.V = v_q;
`else
    assign bus.Z = 1'b0;
    assign bus.N = 1'b0;
    assign bus.V = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param (WIDTH=32); flag expectations follow ALU_PIPE_FLAGS_EN.
module tb_alu_pipe_param;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] f;
        logic         cout;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_pipe_param_if #(.WIDTH(W)) bus ();

    alu_pipe_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic fl(input logic x);
        logic en;
`ifdef ALU_PIPE_FLAGS_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return x & en;
    endfunction

    // Reference behaviour, written from the opcode table using native operators and 64-bit signed range checks.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic dl, input logic dr,
                                   input logic [3:0] s);
        exp_t   e;
        longint sa, sb, r;
        logic   ovf;
        logic [W:0] wide;
        e   = '0;
        ovf = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = 0;
        case (s)
            4'd0: begin
                wide   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                e.f    = wide[W-1:0];
                e.cout = wide[W];
                r      = sa + sb + (cin ? 64'sd1 : 64'sd0);
            end
            4'd1: begin e.f = a - b;  e.cout = (a >= b);          r = sa - sb; end
            4'd2: begin e.f = a + 1;  e.cout = (a == {W{1'b1}});  r = sa + 1;  end
            4'd3: begin e.f = a - 1;  e.cout = (a != '0);         r = sa - 1;  end
            4'd4: e.f = a & b;
            4'd5: e.f = a | b;
            4'd6: e.f = a ^ b;
            4'd7: e.f = ~a;
            4'd8: e.f = {a[W-2:0], dl};
            4'd9: e.f = {dr, a[W-1:1]};
            4'd10: e.f = {a[W-2:0], a[W-1]};
            4'd11: e.f = {a[0], a[W-1:1]};
            4'd12: e.f = a << b[4:0];
            4'd13: e.f = a >> b[4:0];
            default: e.f = '0;
        endcase
        if (s[3:2] == 2'b00) ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.z = (e.f == '0);
        e.n = e.f[W-1];
        e.v = ovf;
`ifndef ALU_PIPE_FLAGS_EN
        e.z = 1'b0;
        e.n = 1'b0;
        e.v = 1'b0;
`endif
        return e;
    endfunction

    task automatic drive(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic dl, input logic dr);
        bus.sel      = s;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.DinL     = dl;
        bus.DinR     = dr;
        bus.in_valid = 1'b1;
    endtask

    // One clock: score any handshake visible now, then advance to the next falling edge.
    task automatic step();
        exp_t got, want;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            got = {bus.F, bus.Cout, bus.Z, bus.N, bus.V};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got %h, none expected", got);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got %h, expected %h", got, want);
                end
            end
        end
        if (bus.in_valid && bus.in_ready)
            sb_q.push_back(model(bus.A, bus.B, bus.Cin, bus.DinL, bus.DinR, bus.sel));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.DinL = 1'b0; bus.DinR = 1'b0; bus.sel = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.F, bus.Cout, bus.Z, bus.N, bus.V} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {bus.out_valid, bus.F, bus.Cout, bus.Z, bus.N, bus.V});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end
    endtask

    task automatic test_arith_edges();
        bus.out_ready = 1'b1;
        drive(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.F, bus.Cout, bus.Z, bus.V} !== {1'b1, 32'h0, 1'b1, fl(1'b1), 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_wrap: got v=%b F=%h C=%b Z=%b V=%b, expected v=1 F=0 C=1 Z=%b V=0",
                     bus.out_valid, bus.F, bus.Cout, bus.Z, bus.V, fl(1'b1));
        end
        step();
        drive(4'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.F, bus.Cout, bus.V, bus.N} !== {1'b1, 32'h7FFF_FFFF, 1'b1, fl(1'b1), 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_ovf: got v=%b F=%h C=%b V=%b N=%b, expected v=1 F=7fffffff C=1 V=%b N=0",
                     bus.out_valid, bus.F, bus.Cout, bus.V, bus.N, fl(1'b1));
        end
        step();
        drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.F, bus.Cout, bus.Z, bus.N, bus.V} !== {32'h0, 1'b0, fl(1'b1), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_zero: got F=%h C=%b Z=%b N=%b V=%b, expected F=0 C=0 Z=%b N=0 V=0",
                     bus.F, bus.Cout, bus.Z, bus.N, bus.V, fl(1'b1));
        end
        step();
    endtask

    task automatic test_shift_latency();
        int cycles;
        bus.out_ready = 1'b1;
        drive(4'd12, 32'h0000_0001, 32'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(4'd0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL shift_in_ready: got %b at cycle %0d, expected 0", bus.in_ready, cycles);
            end
            step();
            cycles++;
        end
        checks++;
        if (cycles != 5 || bus.F !== 32'h0000_0020 || bus.Cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shln_latency: got %0d cycles F=%h C=%b, expected 5 cycles F=00000020 C=0",
                     cycles, bus.F, bus.Cout);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.F !== 32'd7) begin
            errors++;
            $display("[TB] FAIL post_shift_add: got v=%b F=%h, expected v=1 F=00000007", bus.out_valid, bus.F);
        end
        step();
        drive(4'd13, 32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.F !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL shrn_zero: got v=%b F=%h, expected v=1 F=deadbeef", bus.out_valid, bus.F);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        held = 32'hF0F0_1234 ^ 32'h0FF0_4321;
        bus.out_ready = 1'b1;
        drive(4'd6, 32'hF0F0_1234, 32'h0FF0_4321, 1'b0, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        drive(4'd4, 32'hAAAA_5555, 32'h0F0F_FFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.F} !== {1'b0, 1'b1, held}) begin
                errors++;
                $display("[TB] FAIL stall_hold: got rdy=%b v=%b F=%h, expected rdy=0 v=1 F=%h",
                         bus.in_ready, bus.out_valid, bus.F, held);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.F !== 32'h0A0A_5555) begin
            errors++;
            $display("[TB] FAIL stall_release: got v=%b F=%h, expected v=1 F=0a0a5555", bus.out_valid, bus.F);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] s;
        logic [W-1:0] b;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s = 4'($urandom_range(0, 15));
            b = $urandom;
            if (s == 4'd12 || s == 4'd13) b[4:0] = 5'd0;
            drive(s, $urandom, b, 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready: got %b at op %0d, expected 1", bus.in_ready, i);
            end
            step();
        end
        drain();
    endtask

    task automatic test_random_stress();
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                drive(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            else
                bus.in_valid = 1'b0;
            step();
        end
        drain();
    endtask

    task automatic test_reset_mid_shift();
        int bad;
        bus.out_ready = 1'b1;
        drive(4'd12, 32'h0000_1234, 32'd20, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_async: got out_valid=%b, expected 0", bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_release: got rdy=%b v=%b, expected rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rst_abort: got %0d cycles with out_valid, expected 0", bad);
        end
        drive(4'd0, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.F !== 32'd13) begin
            errors++;
            $display("[TB] FAIL rst_next_add: got v=%b F=%h, expected v=1 F=0000000d", bus.out_valid, bus.F);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_arith_edges();
        test_shift_latency();
        test_backpressure();
        test_back_to_back();
        test_random_stress();
        test_reset_mid_shift();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe_param.md
ALU_PIPE_PARAM -- requirements
Module: alu_pipe_param

Interface
- REQ-001: Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
- REQ-002: clk  input  1  sole clock, all state updates on rising edge.
- REQ-003: rst  input  1  asynchronous active-high reset.
- REQ-004: Parameter WIDTH, default 32, operand/result width; legal range 4..64.
- REQ-005: Parameter SHW, default $clog2(WIDTH), shift-amount width, derived and not overridden.
- REQ-006: in_valid  input  1  operation request.
- REQ-007: in_ready  output  1  block can accept; combinational.
- REQ-008: A, B  input  WIDTH each  operands.
- REQ-009: Cin  input  1  carry-in for ADD.
- REQ-010: DinL, DinR  input  1 each  serial-in bits for single-bit SHL/SHR.
- REQ-011: sel  input  4  opcode.
- REQ-012: out_valid  output  1  result valid.
- REQ-013: out_ready  input  1  consumer accepts result.
- REQ-014: F  output  WIDTH  registered result.
- REQ-015: Cout  output  1  registered carry, arithmetic ops only.
- REQ-016: Z, N, V  output  1 each  registered zero/negative/signed-overflow flags.

Function
- REQ-017: Accept SHALL occur on a cycle with in_valid && in_ready; A, B, Cin, DinL, DinR, sel sampled that cycle.
- REQ-018: in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
- REQ-019: Opcodes SHALL be: 0000 ADD A+B+Cin; 0001 SUB A+~B+1; 0010 INC A+1; 0011 DEC A+all-ones; 0100 AND; 0101 OR; 0110 XOR; 0111 NOT A.
- REQ-020: 1000 SHL1 {A[W-2:0],DinL}; 1001 SHR1 {DinR,A[W-1:1]}; 1010 ROL1; 1011 ROR1.
- REQ-021: 1100 SHLN, A logical left by B[SHW-1:0], zero fill; 1101 SHRN, logical right, zero fill; multi-cycle.
- REQ-022: 1110, 1111 reserved: F=0, Cout=0, single-cycle.
- REQ-023: Cout SHALL be the adder carry-out of bit WIDTH-1 for sel[3:2]==00, else 0; SUB Cout=1 means no borrow.
- REQ-024: Single-cycle ops (all except SHLN/SHRN, and SHLN/SHRN with amount 0) SHALL load F/Cout/flags and set out_valid on the edge of accept; visible the next cycle.
- REQ-025: FSM states IDLE, SHIFT: accept of SHLN/SHRN with amount n>0 SHALL load A into a work register, n into a counter, go to SHIFT.
- REQ-026: In SHIFT, one bit shifted per cycle, counter decremented; at counter==1 the final shifted value SHALL load F, set out_valid, return to IDLE; latency n cycles after accept edge.
- REQ-027: in_ready SHALL be 0 throughout SHIFT; in_valid ignored.
- REQ-028: out_valid && !out_ready SHALL hold F/Cout/flags stable; out_valid clears on out_ready unless a new accept reloads the same cycle (back-to-back throughput 1/cycle).
- REQ-029: Width wrap: all results truncated to WIDTH bits; shift amounts >= WIDTH impossible by SHW width except WIDTH not power of 2, where amounts >= WIDTH SHALL yield F=0.

Reset
- REQ-030: rst SHALL force state=IDLE, out_valid=0, F=0, Cout=0, Z=N=V=0, counter=0, work register=0.
- REQ-031: rst asserted mid-SHIFT SHALL abort the operation with no result emitted; in_ready=1 on the first cycle after rst deasserts with out_valid=0.

Configuration
- REQ-032: Macro ALU_PIPE_FLAGS_EN defined: Z=(F==0), N=F[WIDTH-1], V=signed overflow for ADD/SUB/INC/DEC else 0, registered with F.
- REQ-033: Macro undefined: Z, N, V ports SHALL remain present and tied to 0; no flag logic synthesised.

Verification (WIDTH=32, flags macro defined unless noted)
- REQ-034: ADD A=0xFFFFFFFF B=0x00000001 Cin=0 -> next cycle out_valid=1, F=0x00000000, Cout=1, Z=1, V=0.
- REQ-035: SUB A=0x80000000 B=0x00000001 -> F=0x7FFFFFFF, Cout=1, V=1, N=0.
- REQ-036: SHLN A=0x00000001 B=5 -> in_ready=0 for 5 cycles, out_valid at cycle 5 after accept, F=0x00000020, Cout=0; SHRN B=0 -> single-cycle F=A.
- REQ-037: out_ready=0 with result pending, in_valid=1 -> in_ready=0, F stable for 10 cycles; out_ready=1 -> result consumed and new op accepted same cycle.
- REQ-038: rst pulse during SHLN B=20 at cycle 3 -> out_valid stays 0, in_ready=1 after release, next ADD correct.
- REQ-039: Build without ALU_PIPE_FLAGS_EN, ADD 0+0 -> F=0, Z=N=V=0.
